// File: rtl/serial_pkg.sv
// Shared encodings and line levels for the serial link (transmitter and receiver).
package serial_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam logic StartBit  = 1'b0;
  localparam logic StopBit   = 1'b1;
  localparam logic IdleLevel = 1'b1;

  // XORed into the data reduction, so 1 selects odd parity.
  localparam logic ParityOdd = 1'b1;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: tick is high on the last clock of every CLKS_PER_BIT-clock bit period.
module tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic arst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/transmitter.sv
// Serial transmitter: start bit, LSB-first data, odd parity, stop bit(s); all outputs registered.
module transmitter
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  out,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);
  localparam logic [BitCntW-1:0] LastData = BitCntW'(DATA_WIDTH - 1);
  localparam logic [BitCntW-1:0] LastStop = BitCntW'(STOP_BITS - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic                  out_q, out_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  tick;
  logic                  timer_clear;

  // Holding the timer cleared while idle aligns every bit period to the accept edge.
  assign timer_clear = (state_q == StIdle);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .arst (arst),
    .clear(timer_clear),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (valid && ready_q) begin
          state_d   = StStart;
          shift_d   = data;
          parity_d  = (^data) ^ ParityOdd;
          bit_cnt_d = '0;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LastData) begin
            state_d = StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d   = StStop;
          bit_cnt_d = '0;
        end
      end
      StStop: begin
        if (tick) begin
          if (bit_cnt_q == LastStop) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they land in registers on the same edge.
    out_d   = IdleLevel;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    case (state_d)
      StStart:  out_d = StartBit;
      StData:   out_d = shift_d[0];
      StParity: out_d = parity_d;
      StStop:   out_d = StopBit;
      default: begin
        out_d   = IdleLevel;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      out_q     <= IdleLevel;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      out_q     <= out_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ready = ready_q;
  assign out   = out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for transmitter: default instance (C=1, one stop bit) and a C=3, two-stop-bit one.
module tb_transmitter;

  logic       clk = 1'b0;
  logic       arst;
  logic       valid1, valid3;
  logic [7:0] data1, data3;
  logic       ready1, out1, busy1, done1;
  logic       ready3, out3, busy3, done3;

  always #5 clk = ~clk;

  transmitter u_dut1 (
    .clk  (clk),
    .arst (arst),
    .valid(valid1),
    .data (data1),
    .ready(ready1),
    .out  (out1),
    .busy (busy1),
    .done (done1)
  );

  transmitter #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(3),
    .STOP_BITS   (2)
  ) u_dut3 (
    .clk  (clk),
    .arst (arst),
    .valid(valid3),
    .data (data3),
    .ready(ready3),
    .out  (out3),
    .busy (busy3),
    .done (done3)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic s_out(input bit sel);
    return sel ? out3 : out1;
  endfunction
  function automatic logic s_ready(input bit sel);
    return sel ? ready3 : ready1;
  endfunction
  function automatic logic s_busy(input bit sel);
    return sel ? busy3 : busy1;
  endfunction
  function automatic logic s_done(input bit sel);
    return sel ? done3 : done1;
  endfunction

  // Waits (bounded) for ready, presents the word, returns just after the accept edge.
  task automatic send(input bit sel, input logic [7:0] w);
    int t = 0;
    @(negedge clk);
    while (!s_ready(sel) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_send", 32'(s_ready(sel)), 32'd1);
    if (sel) begin
      valid3 = 1'b1;
      data3  = w;
    end else begin
      valid1 = 1'b1;
      data1  = w;
    end
    @(posedge clk);
    #1;
    // Scrambled data after accept must not leak into the frame.
    if (sel) begin
      valid3 = 1'b0;
      data3  = ~w;
    end else begin
      valid1 = 1'b0;
      data1  = ~w;
    end
  endtask

  // Called just after the accept edge; checks every frame cycle and the done cycle.
  task automatic check_frame(input bit sel, input logic [7:0] w, input logic par,
                             input int c, input int sb, input string name);
    logic [11:0] bits;
    int nb;
    nb   = 10 + sb;
    bits = {2'b11, par, w, 1'b0};
    for (int i = 0; i < nb * c; i++) begin
      @(negedge clk);
      check($sformatf("%s_out_cyc%0d", name, i + 1), 32'(s_out(sel)), 32'(bits[i / c]));
      check($sformatf("%s_busy_cyc%0d", name, i + 1), 32'(s_busy(sel)), 32'd1);
      check($sformatf("%s_ready_cyc%0d", name, i + 1), 32'(s_ready(sel)), 32'd0);
      check($sformatf("%s_done_cyc%0d", name, i + 1), 32'(s_done(sel)), 32'd0);
    end
    @(negedge clk);
    check($sformatf("%s_done", name), 32'(s_done(sel)), 32'd1);
    check($sformatf("%s_done_ready", name), 32'(s_ready(sel)), 32'd1);
    check($sformatf("%s_done_out", name), 32'(s_out(sel)), 32'd1);
    check($sformatf("%s_done_busy", name), 32'(s_busy(sel)), 32'd0);
  endtask

  // Independent line receiver used for the loopback test.
  bit         rx_en = 1'b0;
  logic [7:0] sent_q[$];
  logic [8:0] rx_word;
  logic [7:0] rx_exp;
  int         rx_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (rx_en && out1 == 1'b0) begin
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        rx_word[i] = out1;
      end
      @(negedge clk);
      check("lb_stop", 32'(out1), 32'd1);
      check("lb_queue_nonempty", 32'(sent_q.size() != 0), 32'd1);
      if (sent_q.size() != 0) begin
        rx_exp = sent_q.pop_front();
        check($sformatf("lb_data%0d", rx_cnt), 32'(rx_word[7:0]), 32'(rx_exp));
        check($sformatf("lb_par%0d", rx_cnt), 32'(rx_word[8]), 32'(~^rx_exp));
      end
      rx_cnt++;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       par;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1};
    vecs[1] = '{8'h01, 1'b0};
    vecs[2] = '{8'hFF, 1'b1};
    vecs[3] = '{8'h00, 1'b1};
    vecs[4] = '{8'h07, 1'b0};
    vecs[5] = '{8'h3C, 1'b1};

    arst   = 1'b1;
    valid1 = 1'b0;
    valid3 = 1'b0;
    data1  = 8'h00;
    data3  = 8'h00;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    check("rst_out1", 32'(out1), 32'd1);
    check("rst_ready1", 32'(ready1), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    check("rst_out3", 32'(out3), 32'd1);
    check("rst_ready3", 32'(ready3), 32'd1);

    // Table of single frames at C=1.
    for (int v = 0; v < 6; v++) begin
      send(1'b0, vecs[v].d);
      check_frame(1'b0, vecs[v].d, vecs[v].par, 1, 1, $sformatf("vec%0d", v));
    end

    // C=3, two stop bits: 36-cycle frame, done at N+37, then a single-cycle pulse.
    send(1'b1, 8'h3C);
    check_frame(1'b1, 8'h3C, 1'b1, 3, 2, "c3");
    @(negedge clk);
    check("c3_done_one_cycle", 32'(done3), 32'd0);

    // Back-to-back with valid held high: second word taken in the done cycle.
    @(negedge clk);
    valid1 = 1'b1;
    data1  = 8'h55;
    @(posedge clk);
    #1 data1 = 8'hAA;
    check_frame(1'b0, 8'h55, 1'b1, 1, 1, "b2b_first");
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    data1  = 8'h00;
    check_frame(1'b0, 8'hAA, 1'b1, 1, 1, "b2b_second");
    @(negedge clk);
    check("b2b_idle_after", 32'(busy1), 32'd0);
    check("b2b_done_one_cycle", 32'(done1), 32'd0);

    // Reset in the middle of DATA abandons the frame without a done pulse.
    send(1'b0, 8'hA5);
    repeat (4) @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    check("midrst_out", 32'(out1), 32'd1);
    check("midrst_busy", 32'(busy1), 32'd0);
    check("midrst_ready", 32'(ready1), 32'd1);
    check("midrst_done", 32'(done1), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("midrst_no_done%0d", i), 32'(done1), 32'd0);
    end
    send(1'b0, 8'h81);
    check_frame(1'b0, 8'h81, 1'b1, 1, 1, "after_rst");

    // Loopback against the bench receiver.
    rx_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] w;
      w = 8'($urandom_range(0, 255));
      sent_q.push_back(w);
      send(1'b0, w);
    end
    repeat (20) @(negedge clk);
    rx_en = 1'b0;
    check("lb_count", 32'(rx_cnt), 32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
